// File: rtl/alu_result_buffer_if.sv
// Handshake and data bundle between the ALU, the result buffer and its consumer.
// The buffer takes the slave modport; the ALU/consumer side takes the master modport.
interface alu_result_buffer_if #(
   parameter int unsigned BUS_WIDTH = 8,
   parameter int unsigned DEPTH     = 4
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic                 in_valid;
   logic                 in_ready;
   logic [BUS_WIDTH-1:0] y;
   logic [3:0]           opcode;
   logic                 carry_out;
   logic                 borrow_out;
   logic                 zero;
   logic                 parity;
   logic                 invalid_op;
   logic                 out_valid;
   logic                 out_ready;
   logic [BUS_WIDTH-1:0] out_y;
   logic [3:0]           out_opcode;
   logic [3:0]           out_flags;
   logic [CW-1:0]        count;
   logic [7:0]           drop_count;

   modport master (
      output in_valid, y, opcode, carry_out, borrow_out, zero, parity, invalid_op, out_ready,
      input  in_ready, out_valid, out_y, out_opcode, out_flags, count, drop_count
   );

   modport slave (
      input  in_valid, y, opcode, carry_out, borrow_out, zero, parity, invalid_op, out_ready,
      output in_ready, out_valid, out_y, out_opcode, out_flags, count, drop_count
   );
endinterface

// File: rtl/alu_result_buffer.sv
// First-word-fall-through FIFO for ALU results with flags and opcode tag;
// beats flagged invalid_op are consumed and counted (saturating) instead of stored.
module alu_result_buffer #(
   parameter int unsigned BUS_WIDTH = 8,
   parameter int unsigned DEPTH     = 4
) (
   input logic                clk,
   input logic                rst_n,
   input logic                clr,
   alu_result_buffer_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned EW = BUS_WIDTH + 8;

   logic [DEPTH-1:0][EW-1:0] mem;
   logic [PW-1:0]            wr_ptr;
   logic [PW-1:0]            rd_ptr;
   logic [PW-1:0]            count_q;
   logic [7:0]               drop_q;

   logic          full;
   logic          push;
   logic          push_store;
   logic          push_drop;
   logic          pop;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic [EW-1:0] wr_entry;
   logic [EW-1:0] head;

   assign wr_addr  = wr_ptr[AW-1:0];
   assign rd_addr  = rd_ptr[AW-1:0];
   assign full     = (wr_addr == rd_addr) && (wr_ptr[AW] != rd_ptr[AW]);

   assign push       = bus.in_valid && !full;
   assign push_store = push && !bus.invalid_op;
   assign push_drop  = push && bus.invalid_op;
   assign pop        = (count_q != '0) && bus.out_ready;

   assign wr_entry = {bus.y, bus.opcode, bus.carry_out, bus.borrow_out, bus.zero, bus.parity};
   assign head     = mem[rd_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem     <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         drop_q  <= '0;
      end else if (clr) begin
         // storage is intentionally left untouched by a flush
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         drop_q  <= '0;
      end else begin
         if (push_store) begin
            mem[wr_addr] <= wr_entry;
            wr_ptr       <= wr_ptr + PW'(1);
         end
         if (push_drop && (drop_q != '1)) begin
            drop_q <= drop_q + 8'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push_store, pop})
            2'b10:   count_q <= count_q + PW'(1);
            2'b01:   count_q <= count_q - PW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.in_ready   = !full;
   assign bus.out_valid  = (count_q != '0);
   assign bus.out_y      = head[EW-1:8];
   assign bus.out_opcode = head[7:4];
   assign bus.out_flags  = head[3:0];
   assign bus.count      = count_q;
   assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed plus short random bench for alu_result_buffer with a queue scoreboard
// and a small occupancy/drop-count model.
module tb_alu_result_buffer;
   localparam int unsigned BUS_WIDTH = 8;
   localparam int unsigned DEPTH     = 4;

   logic clk;
   logic rst_n;
   logic clr;

   alu_result_buffer_if #(.BUS_WIDTH(BUS_WIDTH), .DEPTH(DEPTH)) bus ();

   alu_result_buffer #(.BUS_WIDTH(BUS_WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] sb [$];
   int unsigned drop_m;
   int unsigned vectors;
   int unsigned miscompares;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] yy, input logic [3:0] op,
                        input logic [3:0] fl, input logic inv, input logic rdy);
      bus.in_valid   = v;
      bus.y          = yy;
      bus.opcode     = op;
      bus.carry_out  = fl[3];
      bus.borrow_out = fl[2];
      bus.zero       = fl[1];
      bus.parity     = fl[0];
      bus.invalid_op = inv;
      bus.out_ready  = rdy;
   endtask

   // One clock: check handshake against the model, score the pop, update the model, then check counters.
   task automatic tick();
      logic        m_push;
      logic        m_pop;
      logic [15:0] e;
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, sb.size() < DEPTH});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, sb.size() != 0});
      m_pop  = (sb.size() != 0) && bus.out_ready && !clr;
      m_push = bus.in_valid && (sb.size() < DEPTH) && !clr;
      if (m_pop) begin
         e = sb.pop_front();
         chk("head_y", {24'd0, bus.out_y}, {24'd0, e[15:8]});
         chk("head_opcode", {28'd0, bus.out_opcode}, {28'd0, e[7:4]});
         chk("head_flags", {28'd0, bus.out_flags}, {28'd0, e[3:0]});
      end
      if (m_push) begin
         if (!bus.invalid_op)
            sb.push_back({bus.y, bus.opcode, bus.carry_out, bus.borrow_out, bus.zero, bus.parity});
         else if (drop_m < 255)
            drop_m++;
      end
      if (clr) begin
         sb.delete();
         drop_m = 0;
      end
      @(posedge clk);
      #1;
      chk("count", {28'd0, bus.count}, sb.size());
      chk("drop_count", {24'd0, bus.drop_count}, drop_m);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      drop_m      = 0;
      rst_n       = 1'b0;
      clr         = 1'b0;
      drive(1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);

      // reset values
      #12;
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_count", {28'd0, bus.count}, 32'd0);
      chk("rst_drop", {24'd0, bus.drop_count}, 32'd0);
      chk("rst_out_y", {24'd0, bus.out_y}, 32'd0);
      chk("rst_out_opcode", {28'd0, bus.out_opcode}, 32'd0);
      chk("rst_out_flags", {28'd0, bus.out_flags}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single beat
      drive(1'b1, 8'h92, 4'h1, 4'b0001, 1'b0, 1'b0);
      tick();
      drive(1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);
      chk("single_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("single_out_y", {24'd0, bus.out_y}, 32'h92);
      chk("single_out_flags", {28'd0, bus.out_flags}, 32'b0001);
      chk("single_out_opcode", {28'd0, bus.out_opcode}, 32'd1);
      bus.out_ready = 1'b1;
      tick();
      chk("single_drained", {31'd0, bus.out_valid}, 32'd0);

      // fill with stall, then push+pop while full, then drain (wraps pointers)
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 8'(i), 4'h3, 4'(i), 1'b0, 1'b0);
         tick();
      end
      chk("fill_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("fill_count", {28'd0, bus.count}, 32'd4);
      drive(1'b1, 8'd5, 4'h3, 4'd5, 1'b0, 1'b0);
      tick();
      chk("fill_held_count", {28'd0, bus.count}, 32'd4);
      bus.out_ready = 1'b1;
      tick();
      chk("full_pop_only", {28'd0, bus.count}, 32'd3);
      tick();
      chk("full_push_pop", {28'd0, bus.count}, 32'd3);
      drive(1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) tick();
      chk("drain_empty", {31'd0, bus.out_valid}, 32'd0);

      // invalid beats
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'hEE, 4'h7, 4'hF, 1'b1, 1'b0);
         tick();
      end
      drive(1'b1, 8'h8C, 4'h2, 4'b1010, 1'b0, 1'b0);
      tick();
      drive(1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);
      chk("inv_drop3", {24'd0, bus.drop_count}, 32'd3);
      chk("inv_count1", {28'd0, bus.count}, 32'd1);
      chk("inv_head_y", {24'd0, bus.out_y}, 32'h8C);
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 8'(i), 4'h7, 4'h0, 1'b1, 1'b0);
         tick();
      end
      chk("inv_saturate", {24'd0, bus.drop_count}, 32'd255);

      // clr: flush, build count=2/drop=5, then clr together with push and pop
      drive(1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      drive(1'b1, 8'h11, 4'h4, 4'b0100, 1'b0, 1'b0);
      tick();
      drive(1'b1, 8'h22, 4'h5, 4'b1000, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'h00, 4'h7, 4'h0, 1'b1, 1'b0);
         tick();
      end
      chk("clr_pre_count", {28'd0, bus.count}, 32'd2);
      chk("clr_pre_drop", {24'd0, bus.drop_count}, 32'd5);
      drive(1'b1, 8'h44, 4'h6, 4'b0010, 1'b0, 1'b1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_count", {28'd0, bus.count}, 32'd0);
      chk("clr_drop", {24'd0, bus.drop_count}, 32'd0);
      chk("clr_out_valid", {31'd0, bus.out_valid}, 32'd0);
      drive(1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);
      tick();
      chk("clr_beat_lost", {28'd0, bus.count}, 32'd0);

      // asynchronous reset mid-stream with count=3
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'hA0 + 8'(i), 4'h9, 4'h1, 1'b0, 1'b0);
         tick();
      end
      chk("arst_pre_count", {28'd0, bus.count}, 32'd3);
      #2;
      rst_n = 1'b0;
      drive(1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);
      #1;
      chk("arst_count", {28'd0, bus.count}, 32'd0);
      chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("arst_drop", {24'd0, bus.drop_count}, 32'd0);
      chk("arst_out_y", {24'd0, bus.out_y}, 32'd0);
      sb.delete();
      drop_m = 0;
      #2;
      rst_n = 1'b1;
      tick();

      // random traffic with stalls and occasional invalid beats
      for (int i = 0; i < 60; i++) begin
         drive(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, 15)),
               4'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
         tick();
      end
      drive(1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH + 1; i++) tick();
      chk("final_empty", {28'd0, bus.count}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
